// File: rtl/clic_dispatch.sv
// rtl/clic_dispatch.sv - CLIC dispatch stage: request/ack handshake, threshold ownership, nesting stack
module clic_dispatch #(
    parameter int N_ENTRIES   = 4,
    parameter int PRIO_W      = 3,
    parameter int IDX_W       = $clog2(N_ENTRIES),
    parameter int DEPTH       = 4,
    parameter int BASE_THRESH = 0,
    localparam int DEP_W      = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 is_interrupt,
    input  logic [IDX_W-1:0]     index,
    input  logic [PRIO_W-1:0]    prio_in,
    output logic [PRIO_W-1:0]    threshold,
    output logic                 irq_req,
    output logic [IDX_W-1:0]     irq_index,
    input  logic                 irq_ack,
    input  logic                 irq_ret,
    output logic [N_ENTRIES-2:0] pend_clr,
    output logic [DEP_W-1:0]     depth,
    output logic                 err
);
    localparam int SP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, REQ} state_t;

    state_t              state, state_n;
    logic [PRIO_W-1:0]   lat_prio, prio_n, thr_n;
    logic [PRIO_W-1:0]   stack [DEPTH];
    logic                req_n, err_n, push, accept;
    logic [IDX_W-1:0]    idx_n;
    logic [DEP_W-1:0]    depth_n;
    logic [N_ENTRIES-2:0] pclr_n;
    logic [SP_W-1:0]     sp_top;

    assign sp_top = SP_W'(depth - 1'b1);
    assign accept = (state == REQ) && irq_ack;

    always_comb begin
        state_n = state;
        req_n   = irq_req;
        idx_n   = irq_index;
        prio_n  = lat_prio;
        thr_n   = threshold;
        depth_n = depth;
        pclr_n  = '0;
        err_n   = err;
        push    = 1'b0;
        case (state)
            IDLE: begin
                if (is_interrupt && (depth != DEP_W'(DEPTH))) begin
                    state_n = REQ;
                    req_n   = 1'b1;
                    idx_n   = index;
                    prio_n  = prio_in;
                end
            end
            REQ: begin
                // Raising the threshold to the accepted priority masks the
                // still-pending entry until its pend bit clears.
                if (irq_ack) begin
                    push    = 1'b1;
                    depth_n = depth + 1'b1;
                    thr_n   = lat_prio;
                    req_n   = 1'b0;
                    state_n = IDLE;
                    for (int i = 0; i < N_ENTRIES - 1; i++)
                        pclr_n[i] = (irq_index == IDX_W'(i));
                    if (irq_ret)
                        err_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (irq_ret && !accept) begin
            if (depth != '0) begin
                thr_n   = stack[sp_top];
                depth_n = depth - 1'b1;
            end else begin
                err_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            irq_req   <= 1'b0;
            irq_index <= '0;
            lat_prio  <= '0;
            threshold <= PRIO_W'(BASE_THRESH);
            depth     <= '0;
            pend_clr  <= '0;
            err       <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                stack[i] <= '0;
        end else begin
            state     <= state_n;
            irq_req   <= req_n;
            irq_index <= idx_n;
            lat_prio  <= prio_n;
            threshold <= thr_n;
            depth     <= depth_n;
            pend_clr  <= pclr_n;
            err       <= err_n;
            if (push)
                stack[SP_W'(depth)] <= threshold;
        end
    end
endmodule

// File: tb/tb_clic_dispatch.sv
// tb/tb_clic_dispatch.sv - randomized and directed bench for clic_dispatch with queue-based model
module tb_clic_dispatch;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       is_interrupt = 1'b0;
    logic [1:0] index = 2'd3;
    logic [2:0] prio_in = 3'd0;
    logic [2:0] threshold;
    logic       irq_req;
    logic [1:0] irq_index;
    logic       irq_ack = 1'b0;
    logic       irq_ret = 1'b0;
    logic [2:0] pend_clr;
    logic [2:0] depth;
    logic       err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: pending request, current threshold and a queue of saved thresholds.
    bit m_req;
    int m_idx, m_prio, m_thr, m_pclr;
    bit m_err;
    int stk[$];

    clic_dispatch dut (
        .clk(clk), .reset(reset), .is_interrupt(is_interrupt), .index(index),
        .prio_in(prio_in), .threshold(threshold), .irq_req(irq_req),
        .irq_index(irq_index), .irq_ack(irq_ack), .irq_ret(irq_ret),
        .pend_clr(pend_clr), .depth(depth), .err(err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_req = 0; m_idx = 0; m_prio = 0; m_thr = 0; m_pclr = 0; m_err = 0;
        stk.delete();
    endtask

    task automatic model_step();
        int d0;
        d0 = stk.size();
        m_pclr = 0;
        if (m_req && irq_ack) begin
            stk.push_back(m_thr);
            m_thr  = m_prio;
            m_pclr = 1 << m_idx;
            m_req  = 0;
            if (irq_ret) m_err = 1;
        end else begin
            if (!m_req && is_interrupt && d0 < DEPTH) begin
                m_req = 1; m_idx = index; m_prio = prio_in;
            end
            if (irq_ret) begin
                if (d0 > 0) m_thr = stk.pop_back();
                else m_err = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic request_ack(input int idx, input int pr);
        is_interrupt = 1'b1; index = 2'(idx); prio_in = 3'(pr);
        tick();
        is_interrupt = 1'b0; index = 2'd3; irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({irq_req, threshold, depth, pend_clr, err} !== 11'd0)
            $display("FAIL reset_initial: got req=%0b thr=%0d depth=%0d pclr=%b err=%0b, want all zero",
                     irq_req, threshold, depth, pend_clr, err);
        else n_pass++;
        request_ack(0, 2);
        request_ack(1, 5);
        is_interrupt = 1'b1; index = 2'd2; prio_in = 3'd6;
        tick();
        is_interrupt = 1'b0;
        n_checks++;
        if (irq_req !== 1'b1 || depth !== 3'd2)
            $display("FAIL reset_setup: got req=%0b depth=%0d, want req=1 depth=2", irq_req, depth);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({irq_req, threshold, depth, pend_clr, err} !== 11'd0)
            $display("FAIL reset_async: got req=%0b thr=%0d depth=%0d pclr=%b err=%0b, want all zero",
                     irq_req, threshold, depth, pend_clr, err);
        else n_pass++;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        do_reset();
        is_interrupt = 1'b1; index = 2'd1; prio_in = 3'd4;
        tick();
        is_interrupt = 1'b0; index = 2'd3;
        n_checks++;
        if (irq_req !== 1'b1 || irq_index !== 2'd1)
            $display("FAIL basic_req: got req=%0b idx=%0d, want req=1 idx=1", irq_req, irq_index);
        else n_pass++;
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        n_checks++;
        if ({irq_req, threshold, depth, pend_clr} !== {1'b0, 3'd4, 3'd1, 3'b010})
            $display("FAIL basic_ack: got req=%0b thr=%0d depth=%0d pclr=%b, want 0 4 1 010",
                     irq_req, threshold, depth, pend_clr);
        else n_pass++;
        tick();
        n_checks++;
        if (pend_clr !== 3'b000 || irq_req !== 1'b0)
            $display("FAIL basic_pclr_pulse: got pclr=%b req=%0b, want 000 0", pend_clr, irq_req);
        else n_pass++;
    endtask

    task automatic test_nesting();
        request_ack(2, 5);
        n_checks++;
        if (threshold !== 3'd5 || depth !== 3'd2 || pend_clr !== 3'b100)
            $display("FAIL nest_push: got thr=%0d depth=%0d pclr=%b, want 5 2 100", threshold, depth, pend_clr);
        else n_pass++;
        irq_ret = 1'b1; tick(); irq_ret = 1'b0;
        n_checks++;
        if (threshold !== 3'd4 || depth !== 3'd1)
            $display("FAIL nest_ret1: got thr=%0d depth=%0d, want 4 1", threshold, depth);
        else n_pass++;
        irq_ret = 1'b1; tick(); irq_ret = 1'b0;
        n_checks++;
        if (threshold !== 3'd0 || depth !== 3'd0 || err !== 1'b0)
            $display("FAIL nest_ret2: got thr=%0d depth=%0d err=%0b, want 0 0 0", threshold, depth, err);
        else n_pass++;
    endtask

    task automatic test_stability();
        do_reset();
        is_interrupt = 1'b1; index = 2'd0; prio_in = 3'd3;
        tick();
        index = 2'd2; prio_in = 3'd6;
        tick(); tick();
        n_checks++;
        if (irq_req !== 1'b1 || irq_index !== 2'd0)
            $display("FAIL stab_hold: got req=%0b idx=%0d, want req=1 idx=0", irq_req, irq_index);
        else n_pass++;
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        n_checks++;
        if (threshold !== 3'd3 || pend_clr !== 3'b001 || irq_req !== 1'b0)
            $display("FAIL stab_ack: got thr=%0d pclr=%b req=%0b, want 3 001 0", threshold, pend_clr, irq_req);
        else n_pass++;
        tick();
        is_interrupt = 1'b0; index = 2'd3;
        n_checks++;
        if (irq_req !== 1'b1 || irq_index !== 2'd2)
            $display("FAIL stab_next: got req=%0b idx=%0d, want req=1 idx=2", irq_req, irq_index);
        else n_pass++;
    endtask

    task automatic test_full_stack();
        bit seen_req;
        do_reset();
        for (int k = 0; k < DEPTH; k++) request_ack(k % 3, k + 1);
        n_checks++;
        if (depth !== 3'd4 || threshold !== 3'd4)
            $display("FAIL full_depth: got depth=%0d thr=%0d, want 4 4", depth, threshold);
        else n_pass++;
        is_interrupt = 1'b1; index = 2'd0; prio_in = 3'd7;
        seen_req = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (irq_req) seen_req = 1;
        end
        n_checks++;
        if (seen_req !== 1'b0)
            $display("FAIL full_block: got a request at depth 4, want none");
        else n_pass++;
        irq_ret = 1'b1; tick(); irq_ret = 1'b0;
        n_checks++;
        if (depth !== 3'd3 || threshold !== 3'd3 || irq_req !== 1'b0)
            $display("FAIL full_ret: got depth=%0d thr=%0d req=%0b, want 3 3 0", depth, threshold, irq_req);
        else n_pass++;
        tick();
        is_interrupt = 1'b0; index = 2'd3;
        n_checks++;
        if (irq_req !== 1'b1 || irq_index !== 2'd0)
            $display("FAIL full_reissue: got req=%0b idx=%0d, want 1 0", irq_req, irq_index);
        else n_pass++;
    endtask

    task automatic test_errors();
        do_reset();
        irq_ret = 1'b1; tick(); irq_ret = 1'b0;
        n_checks++;
        if (err !== 1'b1 || threshold !== 3'd0 || depth !== 3'd0)
            $display("FAIL err_underflow: got err=%0b thr=%0d depth=%0d, want 1 0 0", err, threshold, depth);
        else n_pass++;
        tick();
        n_checks++;
        if (err !== 1'b1)
            $display("FAIL err_sticky: got err=%0b, want 1", err);
        else n_pass++;
        do_reset();
        n_checks++;
        if (err !== 1'b0)
            $display("FAIL err_reset: got err=%0b, want 0", err);
        else n_pass++;
        is_interrupt = 1'b1; index = 2'd1; prio_in = 3'd2;
        tick();
        is_interrupt = 1'b0; index = 2'd3;
        irq_ack = 1'b1; irq_ret = 1'b1; tick(); irq_ack = 1'b0; irq_ret = 1'b0;
        n_checks++;
        if (depth !== 3'd1 || threshold !== 3'd2 || err !== 1'b1 || pend_clr !== 3'b010)
            $display("FAIL err_ack_ret: got depth=%0d thr=%0d err=%0b pclr=%b, want 1 2 1 010",
                     depth, threshold, err, pend_clr);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [12:0] got, exp;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 50) do_reset();
            is_interrupt = 1'($urandom_range(0, 1));
            index        = is_interrupt ? 2'($urandom_range(0, 2)) : 2'd3;
            prio_in      = 3'($urandom_range(0, 7));
            irq_ack      = ($urandom_range(0, 1) == 1);
            irq_ret      = ($urandom_range(0, 5) == 0);
            tick();
            got = {irq_req, irq_index, threshold, depth, pend_clr, err};
            exp = {1'(m_req), 2'(m_idx), 3'(m_thr), 3'(stk.size()), 3'(m_pclr), 1'(m_err)};
            n_checks++;
            if (got !== exp)
                $display("FAIL random_cycle_%0d: got req/idx/thr/depth/pclr/err=%b, want %b", i, got, exp);
            else n_pass++;
        end
        is_interrupt = 1'b0; index = 2'd3; irq_ack = 1'b0; irq_ret = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        test_reset();
        test_basic();
        test_nesting();
        test_stability();
        test_full_stack();
        test_errors();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
